fib_bcd: RTL and testbench

Sequential binary-to-BCD converter that sits directly downstream of the `fib` sequence generator and consumes its `o_fib` result. It captures a WIDTH-bit binary value on a strobe and runs a shift-and-add-3 (double-dabble) conversion, one bit per clock. It then presents DIGITS packed BCD digits with a one-cycle valid pulse, so the sequence value can be shown on a decimal display.

---
 rtl/fib_pkg.sv | 32 +++
 rtl/fib_seg_scan.sv | 51 +++++
 rtl/fib_bcd.sv | 126 ++++++++++++
 tb/tb_fib_bcd.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the fib_bcd converter and its optional display driver.
//   state_e    : converter FSM states (IDLE, SHIFT)
//   digits_ok  : true when DIGITS decimal digits can hold any WIDTH-bit value
//   SEG_GLYPH  : seven-segment glyphs for 0-9, bit 0 = segment a, active-high
//   seg_glyph  : glyph lookup that blanks non-decimal nibbles
package fib_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Only supports WIDTH < 64; 10^DIGITS must exceed 2^WIDTH - 1.
  function automatic bit digits_ok(input int unsigned width, input int unsigned digits);
    longint unsigned pow10;
    longint unsigned max_bin;
    pow10 = 1;
    for (int unsigned i = 0; i < digits; i++) pow10 = pow10 * 10;
    max_bin = (longint'(1) << width) - 1;
    return pow10 > max_bin;
  endfunction

  localparam logic [6:0] SEG_GLYPH [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic logic [6:0] seg_glyph(input logic [3:0] d);
    return (d <= 4'd9) ? SEG_GLYPH[d] : 7'h00;
  endfunction

endpackage

// File: rtl/fib_seg_scan.sv
// Multiplexed seven-segment scan driver for the fib_bcd result.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_bcd          : packed BCD digits, digit 0 in [3:0]
//   o_seg          : registered glyph of the selected digit (a = bit 0)
//   o_dig          : one-hot digit select, digit 0 after reset
// A SCAN_BITS-bit free-running prescaler steps the digit index on wrap.
module fib_seg_scan
  import fib_pkg::*;
#(
  parameter int DIGITS    = 3,
  parameter int SCAN_BITS = 10
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [4*DIGITS-1:0]   i_bcd,
  output logic [6:0]            o_seg,
  output logic [DIGITS-1:0]     o_dig
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [SCAN_BITS-1:0] pre_q;
  logic [IDX_W-1:0]     idx_q;
  logic [6:0]           seg_q;
  logic [3:0]           nib;

  assign nib = i_bcd[int'(idx_q)*4 +: 4];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pre_q <= '0;
      idx_q <= '0;
      seg_q <= 7'h3F;
    end else begin
      pre_q <= pre_q + SCAN_BITS'(1);
      if (&pre_q) begin
        idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
      // glyph lags the select by one cycle
      seg_q <= seg_glyph(nib);
    end
  end

  always_comb begin
    o_dig        = '0;
    o_dig[idx_q] = 1'b1;
  end

  assign o_seg = seg_q;

endmodule

// File: rtl/fib_bcd.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock),
// fed by the fib sequence generator's o_fib output.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_stb          : start request, honoured only while idle
//   i_bin          : WIDTH-bit binary value captured on the accepting edge
//   o_busy         : conversion in progress
//   o_bcd          : DIGITS packed BCD digits, units in [3:0], held between results
//   o_valid        : one-cycle pulse when o_bcd updates
//   o_seg, o_dig   : seven-segment driver outputs, only when FIB_BCD_SEG_EN is defined
// Optional feature macro: FIB_BCD_SEG_EN (adds the multiplexed display driver).
module fib_bcd
  import fib_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIGITS    = 3,
  parameter int SCAN_BITS = 10
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_stb,
  input  logic [WIDTH-1:0]      i_bin,
  output logic                  o_busy,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_valid
`ifdef FIB_BCD_SEG_EN
  ,
  output logic [6:0]            o_seg,
  output logic [DIGITS-1:0]     o_dig
`endif
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < 1) begin : g_bad_width
    $error("fib_bcd: WIDTH must be at least 1");
  end
  if (!digits_ok(WIDTH, DIGITS)) begin : g_bad_digits
    $error("fib_bcd: DIGITS too small for WIDTH");
  end
  if (SCAN_BITS < 1) begin : g_bad_scan
    $error("fib_bcd: SCAN_BITS must be at least 1");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [BCD_W-1:0]  scr_q, scr_d;
  logic [BCD_W-1:0]  adj;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              valid_q, valid_d;

  always_comb begin
    adj = scr_q;
    for (int n = 0; n < DIGITS; n++) begin
      if (scr_q[4*n +: 4] >= 4'd5) adj[4*n +: 4] = scr_q[4*n +: 4] + 4'd3;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_stb) begin
          sr_d    = i_bin;
          scr_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // adjust on the pre-shift scratch, then shift the whole chain left
        {scr_d, sr_d} = {adj, sr_q} << 1;
        cnt_d         = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = scr_d;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
    end
  end

  // working registers carry no reset; IDLE reloads them before use
  always_ff @(posedge i_clk) begin
    sr_q  <= sr_d;
    scr_q <= scr_d;
  end

  assign o_busy  = (state_q == SHIFT);
  assign o_bcd   = bcd_q;
  assign o_valid = valid_q;

`ifdef FIB_BCD_SEG_EN
  fib_seg_scan #(
    .DIGITS    (DIGITS),
    .SCAN_BITS (SCAN_BITS)
  ) u_seg_scan (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_bcd   (bcd_q),
    .o_seg   (o_seg),
    .o_dig   (o_dig)
  );
`endif

endmodule

// File: tb/tb_fib_bcd.sv
// Self-checking bench for fib_bcd (WIDTH=8, DIGITS=3, SCAN_BITS=2).
module tb_fib_bcd;

  localparam int WIDTH     = 8;
  localparam int DIGITS    = 3;
  localparam int SCAN_BITS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        stb;
  logic [7:0]  bin;
  logic        busy;
  logic        valid;
  logic [11:0] bcd;
`ifdef FIB_BCD_SEG_EN
  logic [6:0]  seg;
  logic [2:0]  dig;
`endif

  always #5 clk = ~clk;

  fib_bcd #(
    .WIDTH     (WIDTH),
    .DIGITS    (DIGITS),
    .SCAN_BITS (SCAN_BITS)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_stb   (stb),
    .i_bin   (bin),
    .o_busy  (busy),
    .o_bcd   (bcd),
    .o_valid (valid)
`ifdef FIB_BCD_SEG_EN
    ,
    .o_seg   (seg),
    .o_dig   (dig)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] exp_bcd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // decimal reference by plain arithmetic
  function automatic logic [11:0] dec_ref(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic bit nibbles_ok(input logic [11:0] b);
    return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (b[11:8] <= 4'd9);
  endfunction

  // Call at a negedge with the DUT idle; returns at the negedge where o_valid is seen.
  task automatic convert(input logic [7:0] v, output logic [11:0] res,
                         output int lat, output int busy_n);
    stb = 1'b1;
    bin = v;
    @(negedge clk);
    stb    = 1'b0;
    bin    = 8'($urandom);
    lat    = 0;
    busy_n = 0;
    while (!valid && lat < 40) begin
      if (busy) busy_n++;
      lat++;
      @(negedge clk);
    end
    res = bcd;
  endtask

  vec_t        vecs [10];
  logic [11:0] res;
  int          lat, busy_n;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'd233, 12'h233};
    vecs[1] = '{8'd255, 12'h255};
    vecs[2] = '{8'd0,   12'h000};
    vecs[3] = '{8'd1,   12'h001};
    vecs[4] = '{8'd9,   12'h009};
    vecs[5] = '{8'd10,  12'h010};
    vecs[6] = '{8'd99,  12'h099};
    vecs[7] = '{8'd100, 12'h100};
    vecs[8] = '{8'd144, 12'h144};
    vecs[9] = '{8'd128, 12'h128};

    reset = 1'b1;
    stb   = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy",  32'(busy),  32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_bcd",   32'(bcd),   32'd0);
    reset = 1'b0;
    @(negedge clk);

    // directed table
    foreach (vecs[i]) begin
      convert(vecs[i].bin, res, lat, busy_n);
      chk($sformatf("lat_%0d", vecs[i].bin),  32'(lat),    32'd8);
      chk($sformatf("busy_%0d", vecs[i].bin), 32'(busy_n), 32'd8);
      chk($sformatf("bcd_%0d", vecs[i].bin),  32'(res),    32'(vecs[i].exp_bcd));
      @(negedge clk);
      chk("valid_one_cycle", 32'(valid), 32'd0);
      chk("idle_after",      32'(busy),  32'd0);
      chk("bcd_held",        32'(bcd),   32'(vecs[i].exp_bcd));
    end

    // held strobe: second value accepted only in the valid cycle
    begin
      int          nv = 0;
      int          when [2];
      logic [11:0] got [2];
      stb = 1'b1;
      bin = 8'd144;
      @(negedge clk);
      bin = 8'd89;
      for (int s = 0; s < 30; s++) begin
        if (s == 9) stb = 1'b0;
        if (valid) begin
          if (nv < 2) begin
            when[nv] = s;
            got[nv]  = bcd;
          end
          nv++;
        end
        @(negedge clk);
      end
      chk("hold_valid_count", 32'(nv), 32'd2);
      if (nv >= 2) begin
        chk("hold_first_at",   32'(when[0]), 32'd8);
        chk("hold_first_bcd",  32'(got[0]),  32'h144);
        chk("hold_second_at",  32'(when[1]), 32'd17);
        chk("hold_second_bcd", 32'(got[1]),  32'h089);
      end
    end

    // reset on the 4th busy cycle aborts the conversion
    begin
      int nv = 0;
      stb = 1'b1;
      bin = 8'd21;
      @(negedge clk);
      stb = 1'b0;
      chk("abort_busy_start", 32'(busy), 32'd1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy",  32'(busy),  32'd0);
      chk("abort_bcd",   32'(bcd),   32'd0);
      chk("abort_valid", 32'(valid), 32'd0);
      for (int s = 0; s < 15; s++) begin
        if (valid) nv++;
        @(negedge clk);
      end
      chk("abort_no_valid", 32'(nv), 32'd0);
    end

    // reset and strobe on the same edge: reset wins
    reset = 1'b1;
    stb   = 1'b1;
    bin   = 8'd200;
    @(negedge clk);
    reset = 1'b0;
    stb   = 1'b0;
    chk("rst_stb_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("rst_stb_still_idle", 32'(busy), 32'd0);

    // exhaustive sweep, back-to-back (each strobe lands in the previous valid cycle)
    for (int v = 0; v < 256; v++) begin
      convert(8'(v), res, lat, busy_n);
      chk($sformatf("sweep_lat_%0d", v), 32'(lat), 32'd8);
      chk($sformatf("sweep_bcd_%0d", v), 32'(res), 32'(dec_ref(v)));
      chk($sformatf("sweep_nib_%0d", v), 32'(nibbles_ok(res)), 32'd1);
    end
    @(negedge clk);

    // random values with random idle gaps
    for (int k = 0; k < 40; k++) begin
      int v;
      v = int'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      convert(8'(v), res, lat, busy_n);
      chk($sformatf("rand_lat_%0d", v), 32'(lat), 32'd8);
      chk($sformatf("rand_bcd_%0d", v), 32'(res), 32'(dec_ref(v)));
    end
    @(negedge clk);

`ifdef FIB_BCD_SEG_EN
    begin
      logic [6:0] glyph [10];
      logic [2:0] prev_dig;
      int         last_chg;
      int         idx;
      glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      convert(8'd144, res, lat, busy_n);
      chk("seg_bcd", 32'(res), 32'h144);
      @(negedge clk);
      prev_dig = dig;
      last_chg = -1;
      @(negedge clk);
      for (int s = 0; s < 40; s++) begin
        idx = prev_dig[1] ? 1 : (prev_dig[2] ? 2 : 0);
        chk("seg_glyph", 32'(seg), 32'(glyph[(12'h144 >> (4 * idx)) & 12'hF]));
        if (dig != prev_dig) begin
          chk("dig_rotate", 32'(dig), 32'({prev_dig[1:0], prev_dig[2]}));
          if (last_chg >= 0) chk("dig_period", 32'(s - last_chg), 32'd4);
          last_chg = s;
        end
        prev_dig = dig;
        @(negedge clk);
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
